muldiv_unit: RTL and testbench

Iterative RV32M-style multiply/divide execution unit, parametrised in operand width. It sits beside the single-cycle ALU in the execute stage. The controller steers an instruction here when `ALUOp` is 2'b10 and `Funct7` is 7'b0000001. The unit accepts one operation through a valid/ready handshake, computes it over multiple cycles, and holds the result until the pipeline consumes it.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// Contents: Funct7 code that steers an instruction here, Funct3 operation
// encoding, FSM state encoding, and the is_div() operation classifier.
package muldiv_pkg;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } muldiv_state_e;

   // Divide and remainder ops all have Funct3[2] set.
   function automatic logic is_div(input muldiv_op_e op);
      return op[2];
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: magnitude shift-add multiply and
// restoring divide, one bit per cycle, with sign fix-up in a final cycle.
// Build option: MULDIV_DIV_EN enables the divider; without it, DIV/DIVU/REM/REMU
// complete in one cycle with result 0 and illegal set.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous abort of the operation in flight
//   in_valid/in_ready   request handshake (in_ready high only in IDLE)
//   Funct3, op_a, op_b  operation select and operands
//   out_valid/out_ready result handshake
//   result, illegal     result and unsupported-op flag, held while out_valid
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      Funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            illegal
);

   localparam int unsigned W2 = 2 * XLEN;
   localparam int unsigned CW = $clog2(XLEN + 1);

   muldiv_state_e   state_q, state_d;
   muldiv_op_e      op_q, op_d;
   logic            neg_q, neg_d;
   logic [W2-1:0]   acc_q, acc_d;
   logic [XLEN-1:0] mcand_q, mcand_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            illegal_q, illegal_d;
   logic            out_valid_q, out_valid_d;
   logic            in_ready_q, in_ready_d;

   // Operand decode: which operands are signed and the sign of the final result.
   muldiv_op_e      op_in;
   logic            sgn_a, sgn_b, a_neg, b_neg, is_rem, neg_in;
   logic [XLEN-1:0] a_mag, b_mag;

   assign op_in  = muldiv_op_e'(Funct3);
   assign sgn_a  = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                   (op_in == OP_DIV)  || (op_in == OP_REM);
   assign sgn_b  = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
   assign a_neg  = sgn_a & op_a[XLEN-1];
   assign b_neg  = sgn_b & op_b[XLEN-1];
   assign a_mag  = a_neg ? -op_a : op_a;
   assign b_mag  = b_neg ? -op_b : op_b;
   assign is_rem = op_in[2] & op_in[1];
   // Remainder follows the dividend; everything else is sign(a) ^ sign(b).
   assign neg_in = is_rem ? a_neg : (a_neg ^ b_neg);

   // Multiply step: acc = {partial product, remaining multiplier bits}.
   logic [XLEN:0] mul_sum;
   logic [W2-1:0] mul_next;

   assign mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

   logic [W2-1:0]   prod_fix;
   logic [XLEN-1:0] fix_res;

   assign prod_fix = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   // Restoring divide step: acc = {partial remainder, dividend/quotient bits}.
   logic [XLEN:0]   div_trial;
   logic [W2-1:0]   div_next;
   logic [XLEN-1:0] rem_fix;
   logic            div_ovf;

   assign div_trial = {acc_q[W2-1:XLEN], acc_q[XLEN-1]} - {1'b0, mcand_q};
   // Top bit of the trial difference is the borrow: keep the shifted remainder.
   assign div_next  = div_trial[XLEN] ? {acc_q[W2-2:0], 1'b0}
                                      : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
   assign rem_fix   = neg_q ? -acc_q[W2-1:XLEN] : acc_q[W2-1:XLEN];
   assign div_ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                      (op_a == MIN_NEG) && (op_b == '1);
`endif

   // Final selection; quotient negate equals the low half of the full negate.
   always_comb begin
      fix_res = '0;
      case (op_q)
         OP_MUL:                      fix_res = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[W2-1:XLEN];
`ifdef MULDIV_DIV_EN
         default:                     fix_res = op_q[1] ? rem_fix : prod_fix[XLEN-1:0];
`else
         default:                     fix_res = '0;
`endif
      endcase
   end

   // Next-state and datapath control.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      neg_d     = neg_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      illegal_d = illegal_q;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               op_d      = op_in;
               neg_d     = neg_in;
               acc_d     = {{XLEN{1'b0}}, a_mag};
               mcand_d   = b_mag;
               cnt_d     = CW'(XLEN);
               illegal_d = 1'b0;
               state_d   = CALC;
               if (is_div(op_in)) begin
`ifdef MULDIV_DIV_EN
                  if (op_b == '0) begin
                     result_d = is_rem ? op_a : '1;
                     state_d  = DONE;
                  end else if (div_ovf) begin
                     result_d = is_rem ? '0 : op_a;
                     state_d  = DONE;
                  end
`else
                  result_d  = '0;
                  illegal_d = 1'b1;
                  state_d   = DONE;
`endif
               end
            end
         end
         CALC: begin
`ifdef MULDIV_DIV_EN
            acc_d = is_div(op_q) ? div_next : mul_next;
`else
            acc_d = mul_next;
`endif
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = FIX;
         end
         FIX: begin
            result_d = fix_res;
            state_d  = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (flush) state_d = IDLE;

      out_valid_d = (state_d == DONE);
      in_ready_d  = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= OP_MUL;
         neg_q       <= 1'b0;
         acc_q       <= '0;
         mcand_q     <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         neg_q       <= neg_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         illegal_q   <= illegal_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN = 32). Expected results are
// queued when an operation is issued and compared when out_valid appears.
// Latency is counted in clock edges after the accepting edge:
// 0 for bypass/illegal operations, XLEN+1 for iterative ones.
module tb_muldiv_unit;

   localparam int unsigned XLEN = 32;
   localparam int          LAT_ITER = XLEN + 1;

   logic            clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
   logic [2:0]      Funct3;
   logic [XLEN-1:0] op_a, op_b, result;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] res;
      logic        ill;
      int          lat;
      logic [2:0]  f3;
   } exp_t;

   exp_t sb_q[$];

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .Funct3(Funct3), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model (64-bit arithmetic, truncating signed division).
   function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0]        p;
      logic [31:0]        r;
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      r  = '0;
      case (f3)
         3'd0: begin p = {32'b0, a} * {32'b0, b};             r = p[31:0];  end
         3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
         3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b};       r = p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b};             r = p[63:32]; end
`ifdef MULDIV_DIV_EN
         3'd4: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else r = sa / sb;
         end
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
            else r = sa % sb;
         end
         default: r = (b == 0) ? a : a % b;
`else
         default: r = '0;
`endif
      endcase
      return r;
   endfunction

   function automatic logic model_ill(input logic [2:0] f3);
`ifdef MULDIV_DIV_EN
      return 1'b0;
`else
      return f3[2];
`endif
   endfunction

   function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
`ifdef MULDIV_DIV_EN
      if (f3[2] && (b == 0)) return 0;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return LAT_ITER;
`else
      return f3[2] ? 0 : LAT_ITER + (a == b ? 0 : 0);
`endif
   endfunction

   // Issue one request (called at a negedge) and queue its expectation.
   task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
      exp_t e;
      int   w;
      w = 0;
      while (!in_ready && w < 100) begin @(negedge clk); w++; end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_in_ready: in_ready=%b required 1", in_ready);
      end
      Funct3   = f3;
      op_a     = a;
      op_b     = b;
      in_valid = 1'b1;
      e.res = exp_res; e.ill = exp_ill; e.lat = exp_lat; e.f3 = f3;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      send(f3, a, b, model_res(f3, a, b), model_ill(f3), model_lat(f3, a, b));
   endtask

   // Wait for the result, compare against the queue head, optionally stall.
   task automatic collect(input int hold);
      exp_t e;
      int   n;
      n = 0;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: queue size=0 required >0");
         return;
      end
      e = sb_q.pop_front();
      if (n !== e.lat) begin
         errors++;
         $display("FAIL latency f3=%0d: edges=%0d required %0d", e.f3, n, e.lat);
      end
      checks++;
      if (result !== e.res) begin
         errors++;
         $display("FAIL result f3=%0d: got %h required %h", e.f3, result, e.res);
      end
      checks++;
      if (illegal !== e.ill) begin
         errors++;
         $display("FAIL illegal f3=%0d: got %b required %b", e.f3, illegal, e.ill);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL done_in_ready: got %b required 0", in_ready);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || result !== e.res) begin
            errors++;
            $display("FAIL hold_stable cycle %0d: out_valid=%b result=%h required 1 %h",
                     i, out_valid, result, e.res);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h illegal=%b required 1 0 0 0",
                  in_ready, out_valid, result, illegal);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mul;
      send(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, LAT_ITER); collect(0);
      send(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, LAT_ITER); collect(0);
      send(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, LAT_ITER); collect(0);
      send(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, LAT_ITER); collect(0);
      send(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, LAT_ITER); collect(0);
   endtask

   task automatic test_div;
`ifdef MULDIV_DIV_EN
      send(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, LAT_ITER); collect(0);
      send(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, LAT_ITER); collect(0);
      send(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);                collect(0);
      send(3'd7, 32'd5, 32'd0, 32'd5, 1'b0, 0);                        collect(0);
      send(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);        collect(0);
      send(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0); collect(0);
      send(3'd7, 32'd100, 32'd7, 32'd2, 1'b0, LAT_ITER);               collect(0);
`else
      send(3'd4, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b1, 0);           collect(0);
      send(3'd6, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b1, 0);           collect(0);
      send(3'd5, 32'd5, 32'd0, 32'd0, 1'b1, 0);                   collect(0);
      send(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);   collect(0);
      send(3'd7, 32'd100, 32'd7, 32'd0, 1'b1, 0);                 collect(0);
`endif
   endtask

   task automatic test_backpressure;
      send(3'd0, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0, LAT_ITER);
      collect(5);
   endtask

   // Abort an operation 10 cycles into CALC by reset or by flush.
   task automatic test_abort(input logic use_rst);
      int seen;
      Funct3 = 3'd0; op_a = 32'h55; op_b = 32'h77; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      if (use_rst) begin
         rst_n = 1'b0;
         #1;
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL abort_reset: in_ready=%b out_valid=%b result=%h required 1 0 0",
                     in_ready, out_valid, result);
         end
         @(negedge clk);
         rst_n = 1'b1;
      end else begin
         flush = 1'b1;
         @(posedge clk);
         @(negedge clk);
         flush = 1'b0;
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_flush: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
         end
         // Flush wins over a request in the same cycle.
         Funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1; flush = 1'b1;
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0; flush = 1'b0;
      end
      seen = 0;
      repeat (XLEN + 8) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL abort_no_result use_rst=%b: out_valid cycles=%0d required 0", use_rst, seen);
      end
      send(3'd0, 32'd3, 32'd4, 32'd12, 1'b0, LAT_ITER);
      collect(0);
   endtask

   task automatic test_back_to_back;
      logic [2:0]  f3;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         send_model(f3, a, b);
         collect(i % 3);
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      Funct3 = 3'd0; op_a = '0; op_b = '0;
      test_reset();
      test_mul();
      test_div();
      test_backpressure();
      test_abort(1'b1);
      test_abort(1'b0);
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
